// File: rtl/ppu_line_doubler_ctrl.sv
// ppu_line_doubler_ctrl: ping-pong line buffer scheduler showing each PPU line on two output lines
module ppu_line_doubler_ctrl #(
  parameter int H_ACTIVE = 256,
  parameter int X_OFFSET = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ppu_pix_valid,
  input  logic [14:0]   ppu_pixel,
  input  logic          ppu_line_start,
  input  logic          ppu_frame_start,
  input  logic          vga_line_start,
  input  logic          vga_frame_start,
  input  logic [9:0]    next_pixel_x,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [14:0]   wr_data,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          border,
  output logic          locked,
  output logic          underrun,
  output logic          overrun
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT_VGA, RUN} state_t;
  state_t state_q, state_d;
  logic [AW:0] cnt_q, cnt_d, cnt_s;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [14:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic ready_q, ready_d, done_bank_q, done_bank_d, rep_q, rep_d;
  logic border_q, border_d, underrun_q, underrun_d, overrun_q, overrun_d;
  logic active, ls, wr, done, ready_s, last_s, rep_s, swap_t, align, run;
  always_comb begin
    run         = state_q == RUN;
    active      = state_q != IDLE || ppu_frame_start;
    ls          = active && ppu_line_start;
    cnt_s       = ls ? '0 : cnt_q;
    wr          = active && ppu_pix_valid && cnt_s < (AW+1)'(H_ACTIVE);
    done        = wr && cnt_s == (AW+1)'(H_ACTIVE - 1);
    ready_s     = ready_q || done;
    last_s      = done ? wr_bank_q : done_bank_q;
    rep_s       = vga_frame_start ? 1'b0 : rep_q;
    swap_t      = run && vga_line_start && rep_s;
    align       = state_q == WAIT_VGA && vga_frame_start;
    rd_bank_d   = align ? wr_bank_q : (swap_t && ready_s) ? last_s : rd_bank_q;
    wr_bank_d   = ls ? ~rd_bank_d : wr_bank_q;
    ready_d     = (align || (swap_t && ready_s)) ? 1'b0 : ready_s;
    done_bank_d = done ? wr_bank_q : done_bank_q;
    rep_d       = align ? 1'b0 : (run && vga_line_start) ? ~rep_s : rep_q;
    cnt_d       = wr ? cnt_s + 1'b1 : cnt_s;
    wr_en_d     = wr;
    wr_addr_d   = cnt_s[AW-1:0];
    wr_data_d   = ppu_pixel;
    underrun_d  = swap_t && !ready_s;
    overrun_d   = done && ready_q && !swap_t && !align;
    border_d    = !run || next_pixel_x < 10'(X_OFFSET) ||
                  next_pixel_x >= 10'(X_OFFSET + 2*H_ACTIVE);
    state_d     = (state_q == IDLE && ppu_frame_start) ? FILL :
                  (state_q == FILL && done) ? WAIT_VGA :
                  align ? RUN : state_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b1;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_bank_q   <= 1'b0;
      ready_q     <= 1'b0;
      done_bank_q <= 1'b0;
      rep_q       <= 1'b0;
      border_q    <= 1'b1;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_bank_q   <= rd_bank_d;
      ready_q     <= ready_d;
      done_bank_q <= done_bank_d;
      rep_q       <= rep_d;
      border_q    <= border_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end
  assign rd_addr  = AW'((next_pixel_x - 10'(X_OFFSET)) >> 1);
  assign wr_en    = wr_en_q;
  assign wr_bank  = wr_bank_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_bank  = rd_bank_q;
  assign border   = border_q;
  assign locked   = state_q == RUN;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;
endmodule
